// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: the CPU MEM stage owns the port by default. An external
// loader gets one-cycle grants, forced through after STARVE_LIMIT waiting cycles.

module dmem_port_arbiter_chk (
  input logic       clk,
  input logic       reset,
  input logic [1:0] state,
  input logic       cpu_stall,
  input logic       ext_ack
);

  localparam logic [1:0] EXT_CODE = 2'd1;

  // ack only ever follows an EXT cycle, stall only ever happens inside EXT
  ack_after_ext: assert property (@(posedge clk) disable iff (reset)
    ext_ack |-> $past(state == EXT_CODE));

  stall_only_in_ext: assert property (@(posedge clk) disable iff (reset)
    cpu_stall |-> (state == EXT_CODE));

endmodule

module dmem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_mem_read,
  input  logic        cpu_mem_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        ext_req,
  input  logic        ext_we,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  output logic        ext_ack,
  output logic [31:0] ext_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXT  = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state_r;
  state_t      state_s;
  logic [3:0]  wait_cnt_r;
  logic [3:0]  wait_cnt_s;
  logic        cpu_access_s;
  logic        ext_ack_r;
  logic [31:0] ext_rdata_r;
  logic [15:0] stall_count_r;

  // next-state, starvation counter and port mux
  always_comb begin
    cpu_access_s = cpu_mem_read | cpu_mem_write;
    state_s      = state_r;
    wait_cnt_s   = 4'd0;
    mem_read     = cpu_mem_read;
    mem_write    = cpu_mem_write;
    mem_addr     = cpu_addr;
    mem_wdata    = cpu_wdata;
    cpu_rdata    = mem_rdata;
    cpu_stall    = 1'b0;
    if (reset) begin
      state_s   = IDLE;
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (ext_req && (!cpu_access_s || wait_cnt_r == LIMIT)) begin
            state_s = EXT;
          end else if (ext_req) begin
            // still blocked by a CPU access: age the request
            wait_cnt_s = wait_cnt_r + 4'd1;
          end else begin
            wait_cnt_s = 4'd0;
          end
        end
        EXT: begin
          mem_addr  = ext_addr;
          mem_wdata = ext_wdata;
          mem_write = ext_we;
          mem_read  = ~ext_we;
          cpu_rdata = 32'd0;
          cpu_stall = cpu_access_s;
          state_s   = ACK;
        end
        ACK: begin
          state_s = IDLE;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // state, ack/read-data capture and saturating stall counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      wait_cnt_r    <= 4'd0;
      ext_ack_r     <= 1'b0;
      ext_rdata_r   <= 32'd0;
      stall_count_r <= 16'd0;
    end else begin
      state_r    <= state_s;
      wait_cnt_r <= wait_cnt_s;
      ext_ack_r  <= (state_r == EXT);
      if (state_r == EXT && !ext_we) begin
        ext_rdata_r <= mem_rdata;
      end
      if (cpu_stall && stall_count_r != 16'hFFFF) begin
        stall_count_r <= stall_count_r + 16'd1;
      end
    end
  end

  assign ext_ack     = ext_ack_r;
  assign ext_rdata   = ext_rdata_r;
  assign stall_count = stall_count_r;

  dmem_port_arbiter_chk u_chk (
    .clk       (clk),
    .reset     (reset),
    .state     (state_r),
    .cpu_stall (cpu_stall),
    .ext_ack   (ext_ack)
  );

endmodule
